// File: rtl/spi_reg_bank.sv
// ---------------------------------------------------------------------------
// spi_reg_bank
//   Byte-level command decoder and register file sitting behind spi_slave.
//   The first byte of a chip-select-low transaction is a command
//   (bit7 = 1 write, 0 read; bits[6:0] start address); following bytes
//   write or read consecutive registers. The register file is exported flat
//   on o_Regs to configure the DDA core.
//
// Ports
//   i_Clk       system clock
//   i_Rst_L     asynchronous active-low reset
//   i_RX_DV     1-cycle pulse, i_RX_Byte valid
//   i_RX_Byte   byte received from spi_slave
//   i_SPI_CS_n  raw chip select (asynchronous, synchronised here)
//   o_TX_DV     1-cycle pulse, load o_TX_Byte into spi_slave
//   o_TX_Byte   byte for spi_slave to shift out on MISO
//   o_Wr_Stb    1-cycle pulse per accepted register write
//   o_Wr_Addr   address of the last accepted write
//   o_Wr_Data   data of the last accepted write
//   o_Regs      flat register file, register n at [8n+7:8n]
//   o_Busy      high while a transaction is being decoded
// ---------------------------------------------------------------------------
module spi_reg_bank #(
   parameter int          NUM_REGS  = 16,
   parameter logic [7:0]  IDLE_BYTE = 8'hA5
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_L,
   input  logic                  i_RX_DV,
   input  logic [7:0]            i_RX_Byte,
   input  logic                  i_SPI_CS_n,
   output logic                  o_TX_DV,
   output logic [7:0]            o_TX_Byte,
   output logic                  o_Wr_Stb,
   output logic [6:0]            o_Wr_Addr,
   output logic [7:0]            o_Wr_Data,
   output logic [NUM_REGS*8-1:0] o_Regs,
   output logic                  o_Busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } stateT;

   stateT       state_q, state_d;
   logic [6:0]  ptr_q, ptr_d;
   logic        csMeta_q, csSync_q, csSyncDly_q;
   logic        txDv_q, txDv_d;
   logic [7:0]  txByte_q, txByte_d;
   logic        wrStb_q, wrStb_d;
   logic [6:0]  wrAddr_q, wrAddr_d;
   logic [7:0]  wrData_q, wrData_d;
   logic        idlePend_q, idlePend_d;
   logic [7:0]  regs_q [NUM_REGS];

   logic        csRise;
   logic        decodeAsCmd;
   logic        ptrInRange;
   logic        wrEn;
   logic [6:0]  rdAddr;
   logic [7:0]  rdData;

   // Chip select synchroniser plus one delay stage for edge detection. All
   // three flops reset high so that leaving reset never looks like a CS rise.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         csMeta_q    <= 1'b1;
         csSync_q    <= 1'b1;
         csSyncDly_q <= 1'b1;
      end else begin
         csMeta_q    <= i_SPI_CS_n;
         csSync_q    <= csMeta_q;
         csSyncDly_q <= csSync_q;
      end
   end

   assign csRise = csSync_q & ~csSyncDly_q;

   // A byte is decoded as a command when no transaction is open, or when CS
   // still reads high outside the rise cycle. On the rise cycle itself a byte
   // still belongs to the transaction that is closing.
   assign decodeAsCmd = (state_q == ST_IDLE) || (csSync_q && !csRise);

   assign ptrInRange = ({25'd0, ptr_q} < 32'(NUM_REGS));

   // Read port: commands read the address in the byte itself, READ-state
   // bytes read at the running pointer. Addresses past the file read 0.
   assign rdAddr = decodeAsCmd ? i_RX_Byte[6:0] : ptr_q;

   always_comb begin
      rdData = 8'h00;
      for (int n = 0; n < NUM_REGS; n++) begin
         if (rdAddr == 7'(n)) begin
            rdData = regs_q[n];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: a CS rise always closes the transaction, even if a byte
   // arrives in the same cycle (that byte is still processed below).
   always_comb begin
      state_d = state_q;
      if (csRise) begin
         state_d = ST_IDLE;
      end else if (i_RX_DV && decodeAsCmd) begin
         state_d = i_RX_Byte[7] ? ST_WRITE : ST_READ;
      end
   end

   // FSM outputs and datapath next values. A byte-driven TX load wins over
   // the IDLE_BYTE load; when both fall in the rise cycle the IDLE_BYTE load
   // is deferred one cycle via idlePend so the two pulses stay separate.
   always_comb begin
      txDv_d     = 1'b0;
      txByte_d   = txByte_q;
      wrStb_d    = 1'b0;
      wrAddr_d   = wrAddr_q;
      wrData_d   = wrData_q;
      ptr_d      = ptr_q;
      wrEn       = 1'b0;
      idlePend_d = csRise & i_RX_DV;

      if (i_RX_DV) begin
         if (decodeAsCmd) begin
            ptr_d = i_RX_Byte[6:0];
            if (!i_RX_Byte[7]) begin
               txDv_d   = 1'b1;
               txByte_d = rdData;
               ptr_d    = i_RX_Byte[6:0] + 7'd1;
            end
         end else if (state_q == ST_WRITE) begin
            wrEn    = ptrInRange;
            wrStb_d = ptrInRange;
            if (ptrInRange) begin
               wrAddr_d = ptr_q;
               wrData_d = i_RX_Byte;
            end
            ptr_d = ptr_q + 7'd1;
         end else begin
            txDv_d   = 1'b1;
            txByte_d = rdData;
            ptr_d    = ptr_q + 7'd1;
         end
      end else if (csRise || idlePend_q) begin
         txDv_d   = 1'b1;
         txByte_d = IDLE_BYTE;
      end
   end

   // Registered outputs and pointer.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         ptr_q      <= 7'd0;
         txDv_q     <= 1'b0;
         txByte_q   <= IDLE_BYTE;
         wrStb_q    <= 1'b0;
         wrAddr_q   <= 7'd0;
         wrData_q   <= 8'h00;
         idlePend_q <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         txDv_q     <= txDv_d;
         txByte_q   <= txByte_d;
         wrStb_q    <= wrStb_d;
         wrAddr_q   <= wrAddr_d;
         wrData_q   <= wrData_d;
         idlePend_q <= idlePend_d;
      end
   end

   // Register file; the write lands on the same edge that raises o_Wr_Stb,
   // so the new value is visible while the strobe is high.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         for (int n = 0; n < NUM_REGS; n++) begin
            regs_q[n] <= 8'h00;
         end
      end else begin
         for (int n = 0; n < NUM_REGS; n++) begin
            if (wrEn && (ptr_q == 7'(n))) begin
               regs_q[n] <= i_RX_Byte;
            end
         end
      end
   end

   // Flatten the register file for the core.
   always_comb begin
      o_Regs = '0;
      for (int n = 0; n < NUM_REGS; n++) begin
         o_Regs[n*8 +: 8] = regs_q[n];
      end
   end

   assign o_TX_DV   = txDv_q;
   assign o_TX_Byte = txByte_q;
   assign o_Wr_Stb  = wrStb_q;
   assign o_Wr_Addr = wrAddr_q;
   assign o_Wr_Data = wrData_q;
   assign o_Busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_bank
//   Self-checking bench for spi_reg_bank. Transactions are driven at byte
//   level; expected TX bytes, write strobes and register contents come from
//   a plain array model of the register file with a wrapping 7-bit address.
// ---------------------------------------------------------------------------
module tb_spi_reg_bank;

   localparam int         NUM_REGS  = 16;
   localparam logic [7:0] IDLE_BYTE = 8'hA5;

   logic                  clock = 1'b0;
   logic                  rstN;
   logic                  rxDv;
   logic [7:0]            rxByte;
   logic                  csN;
   logic                  txDv;
   logic [7:0]            txByte;
   logic                  wrStb;
   logic [6:0]            wrAddr;
   logic [7:0]            wrData;
   logic [NUM_REGS*8-1:0] regs;
   logic                  busy;

   int                    checkCount = 0;
   int                    errorCount = 0;

   logic [7:0]            modelRegs [NUM_REGS];
   logic [7:0]            payload   [8];

   spi_reg_bank #(
      .NUM_REGS  (NUM_REGS),
      .IDLE_BYTE (IDLE_BYTE)
   ) dut (
      .i_Clk      (clock),
      .i_Rst_L    (rstN),
      .i_RX_DV    (rxDv),
      .i_RX_Byte  (rxByte),
      .i_SPI_CS_n (csN),
      .o_TX_DV    (txDv),
      .o_TX_Byte  (txByte),
      .o_Wr_Stb   (wrStb),
      .o_Wr_Addr  (wrAddr),
      .o_Wr_Data  (wrData),
      .o_Regs     (regs),
      .o_Busy     (busy)
   );

   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Model read: anything past the register file reads as zero.
   function automatic logic [7:0] modelVal(input int addr);
      return (addr < NUM_REGS) ? modelRegs[addr] : 8'h00;
   endfunction

   task automatic modelReset();
      for (int n = 0; n < NUM_REGS; n++) modelRegs[n] = 8'h00;
   endtask

   task automatic checkRegs(input string tag);
      for (int n = 0; n < NUM_REGS; n++) begin
         checkOutput($sformatf("%s_reg%0d", tag, n), 32'(regs[n*8 +: 8]), 32'(modelRegs[n]));
      end
   endtask

   // Sends one byte and checks the response one cycle later, then checks
   // that both pulses last exactly one cycle.
   task automatic applyStimulus(input logic [7:0] b, input bit expTx, input logic [7:0] expTxByte,
                                input bit expWr, input int expAddr, input logic [7:0] expData,
                                input bit expBusy);
      @(negedge clock);
      rxDv   = 1'b1;
      rxByte = b;
      @(negedge clock);
      rxDv   = 1'b0;
      checkOutput("tx_dv", 32'(txDv), 32'(expTx));
      if (expTx) checkOutput("tx_byte", 32'(txByte), 32'(expTxByte));
      checkOutput("wr_stb", 32'(wrStb), 32'(expWr));
      if (expWr) begin
         checkOutput("wr_addr", 32'(wrAddr), 32'(7'(expAddr)));
         checkOutput("wr_data", 32'(wrData), 32'(expData));
      end
      checkOutput("busy", 32'(busy), 32'(expBusy));
      @(negedge clock);
      checkOutput("tx_dv_pulse", 32'(txDv), 32'd0);
      checkOutput("wr_stb_pulse", 32'(wrStb), 32'd0);
      repeat (5) @(negedge clock);
   endtask

   task automatic csLow();
      @(negedge clock);
      csN = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   // Raises CS and expects the IDLE_BYTE load three cycles later
   // (two synchroniser stages plus the registered output).
   task automatic csHigh();
      @(negedge clock);
      csN = 1'b1;
      @(negedge clock);
      checkOutput("cs_tx_early1", 32'(txDv), 32'd0);
      @(negedge clock);
      checkOutput("cs_tx_early2", 32'(txDv), 32'd0);
      checkOutput("cs_busy_before", 32'(busy), 32'd1);
      @(negedge clock);
      checkOutput("cs_tx_dv", 32'(txDv), 32'd1);
      checkOutput("cs_tx_byte", 32'(txByte), 32'(IDLE_BYTE));
      checkOutput("cs_busy_after", 32'(busy), 32'd0);
      @(negedge clock);
      checkOutput("cs_tx_pulse", 32'(txDv), 32'd0);
      repeat (3) @(negedge clock);
   endtask

   task automatic doWrite(input int start, input int n);
      int addr;
      csLow();
      applyStimulus({1'b1, 7'(start)}, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b1);
      for (int i = 0; i < n; i++) begin
         addr = (start + i) % 128;
         if (addr < NUM_REGS) begin
            modelRegs[addr] = payload[i];
            applyStimulus(payload[i], 1'b0, 8'h00, 1'b1, addr, payload[i], 1'b1);
         end else begin
            applyStimulus(payload[i], 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b1);
         end
      end
      csHigh();
      checkRegs("wr");
   endtask

   task automatic doRead(input int start, input int n);
      csLow();
      applyStimulus({1'b0, 7'(start)}, 1'b1, modelVal(start), 1'b0, 0, 8'h00, 1'b1);
      for (int i = 1; i <= n; i++) begin
         applyStimulus(8'($urandom), 1'b1, modelVal((start + i) % 128), 1'b0, 0, 8'h00, 1'b1);
      end
      csHigh();
   endtask

   initial begin
      rstN   = 1'b0;
      csN    = 1'b1;
      rxDv   = 1'b0;
      rxByte = 8'h00;
      modelReset();
      repeat (3) @(negedge clock);
      rstN = 1'b1;
      @(negedge clock);

      // Reset state.
      checkOutput("rst_tx_dv", 32'(txDv), 32'd0);
      checkOutput("rst_tx_byte", 32'(txByte), 32'(IDLE_BYTE));
      checkOutput("rst_wr_stb", 32'(wrStb), 32'd0);
      checkOutput("rst_wr_addr", 32'(wrAddr), 32'd0);
      checkOutput("rst_wr_data", 32'(wrData), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkRegs("rst");

      // Burst write at 3.
      payload[0] = 8'h11;
      payload[1] = 8'h22;
      doWrite(3, 2);
      checkOutput("t1_reg3", 32'(regs[31:24]), 32'h11);
      checkOutput("t1_reg4", 32'(regs[39:32]), 32'h22);

      // Preload then burst read from 5.
      payload[0] = 8'h5A;
      payload[1] = 8'hC3;
      doWrite(5, 2);
      doRead(5, 2);

      // Write starting at 127: first byte dropped, pointer wraps to 0.
      payload[0] = 8'h01;
      payload[1] = 8'h02;
      doWrite(127, 2);
      checkOutput("t3_reg0", 32'(regs[7:0]), 32'h02);

      // Read running off the end of the file.
      doRead(15, 2);

      // Data byte coincident with the synchronised CS rise.
      csLow();
      applyStimulus(8'h88, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b1);
      @(negedge clock);
      csN = 1'b1;
      @(negedge clock);
      @(negedge clock);
      rxDv   = 1'b1;
      rxByte = 8'h77;
      @(negedge clock);
      rxDv = 1'b0;
      modelRegs[8] = 8'h77;
      checkOutput("t5_wr_stb", 32'(wrStb), 32'd1);
      checkOutput("t5_wr_addr", 32'(wrAddr), 32'd8);
      checkOutput("t5_wr_data", 32'(wrData), 32'h77);
      checkOutput("t5_tx_dv_first", 32'(txDv), 32'd0);
      checkOutput("t5_busy", 32'(busy), 32'd0);
      @(negedge clock);
      checkOutput("t5_tx_dv_idle", 32'(txDv), 32'd1);
      checkOutput("t5_tx_byte_idle", 32'(txByte), 32'(IDLE_BYTE));
      checkOutput("t5_wr_stb_off", 32'(wrStb), 32'd0);
      @(negedge clock);
      checkOutput("t5_tx_dv_off", 32'(txDv), 32'd0);
      repeat (3) @(negedge clock);
      checkRegs("t5");

      // Reset in the middle of a write transaction.
      csLow();
      applyStimulus(8'h82, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b1);
      @(negedge clock);
      rstN = 1'b0;
      modelReset();
      repeat (2) @(negedge clock);
      checkOutput("t6_busy_rst", 32'(busy), 32'd0);
      checkRegs("t6_rst");
      rstN = 1'b1;
      repeat (4) @(negedge clock);
      applyStimulus(8'h81, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b1);
      modelRegs[1] = 8'h44;
      applyStimulus(8'h44, 1'b0, 8'h00, 1'b1, 1, 8'h44, 1'b1);
      csHigh();
      checkRegs("t6");

      // Randomised transactions, biased toward the file end and the wrap.
      for (int t = 0; t < 40; t++) begin
         int start;
         int len;
         case ($urandom_range(0, 3))
            0:       start = int'($urandom_range(0, 15));
            1:       start = int'($urandom_range(12, 20));
            2:       start = int'($urandom_range(124, 127));
            default: start = int'($urandom_range(0, 127));
         endcase
         len = int'($urandom_range(0, 5));
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 8; i++) payload[i] = 8'($urandom);
            doWrite(start, len);
         end else begin
            doRead(start, len);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
